// File: rtl/col_drain.sv
// ============================================================================
// Module   : col_drain
// Purpose  : Column result drain for the systolic PE array. Holds each row's
//            result until the whole tile column has arrived, then streams the
//            results out row by row over a valid/ready handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_res     in   ROWS*OUTWIDTH, row r result at [r*OUTWIDTH +: OUTWIDTH]
//   in_valids  in   ROWS, per-row one-cycle result strobe
//   out_r      out  OUTWIDTH, drained result
//   out_row    out  RW, row index of out_r
//   out_valid  out  out_r/out_row valid
//   out_ready  in   downstream accept
//   done       out  one-cycle pulse after the last row of a tile is drained
//   tile_cnt   out  16-bit completed-tile counter (wraps)
//   ovf        out  sticky overrun flag
// Build option
//   COL_DRAIN_OVF_EN : when defined, overrun detection drives a sticky ovf;
//                      otherwise ovf is tied low.
// ============================================================================
`default_nettype none

module col_drain #(
  parameter  int ROWS     = 8,
  parameter  int OUTWIDTH = 32,
  localparam int RW       = $clog2(ROWS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*OUTWIDTH-1:0] in_res,
  input  logic [ROWS-1:0]          in_valids,
  output logic [OUTWIDTH-1:0]      out_r,
  output logic [RW-1:0]            out_row,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic [15:0]              tile_cnt,
  output logic                     ovf
);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OUTWIDTH-1:0] r_hold [ROWS];
  logic [ROWS-1:0]     r_pend;
  logic [ROWS-1:0]     w_pend_nxt;
  logic [ROWS-1:0]     w_release;
  logic [ROWS-1:0]     w_capture;
  logic [RW-1:0]       r_ptr;
  logic                r_done;
  logic [15:0]         r_tile_cnt;
  logic                w_hs;
  logic                w_last;

  assign w_hs   = (r_state == DRAIN) && out_ready;
  assign w_last = w_hs && (r_ptr == RW'(ROWS - 1));

  // A row being released this cycle may take a new strobe: capture wins,
  // so pend stays set and the handshaken beat still carries the old value.
  always_comb begin
    w_release  = '0;
    w_capture  = '0;
    w_pend_nxt = r_pend;
    for (int r = 0; r < ROWS; r++) begin
      w_release[r] = w_hs && (r_ptr == RW'(r));
      w_capture[r] = in_valids[r] && (!r_pend[r] || w_release[r]);
      if (w_capture[r]) begin
        w_pend_nxt[r] = 1'b1;
      end else if (w_release[r]) begin
        w_pend_nxt[r] = 1'b0;
      end
    end
  end

  // Next state and outputs. COLLECT looks at the post-capture pend vector so
  // the last arriving row starts the drain one cycle later. Leaving DRAIN
  // always passes through COLLECT, which forces the inter-tile bubble.
  always_comb begin
    w_state_nxt = r_state;
    out_valid   = 1'b0;
    out_r       = '0;
    case (r_state)
      COLLECT: begin
        if (&w_pend_nxt) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_r     = r_hold[r_ptr];
        if (w_last) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= COLLECT;
      r_pend     <= '0;
      r_ptr      <= '0;
      r_done     <= 1'b0;
      r_tile_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_done  <= w_last;
      if (w_last) begin
        r_ptr      <= '0;
        r_tile_cnt <= r_tile_cnt + 16'd1;
      end else if (w_hs) begin
        r_ptr <= r_ptr + RW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (rst) begin
        r_hold[r] <= '0;
      end else if (w_capture[r]) begin
        r_hold[r] <= in_res[r*OUTWIDTH +: OUTWIDTH];
      end
    end
  end

`ifdef COL_DRAIN_OVF_EN
  logic r_ovf;
  logic w_overrun;

  // Strobe on a still-pending row that is not draining now: value dropped.
  assign w_overrun = |(in_valids & r_pend & ~w_release);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_overrun) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign out_row  = r_ptr;
  assign done     = r_done;
  assign tile_cnt = r_tile_cnt;

endmodule

`default_nettype wire

// File: tb/tb_col_drain.sv
// ============================================================================
// Module   : tb_col_drain
// Purpose  : Directed self-checking bench for col_drain (ROWS=4). Expected
//            beats are queued as stimulus is driven and popped as the DUT
//            hands them off.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_col_drain;

  localparam int ROWS     = 4;
  localparam int OUTWIDTH = 32;
  localparam int RW       = 2;
`ifdef COL_DRAIN_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [ROWS*OUTWIDTH-1:0] in_res = '0;
  logic [ROWS-1:0]          in_valids = '0;
  logic [OUTWIDTH-1:0]      out_r;
  logic [RW-1:0]            out_row;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic                     done;
  logic [15:0]              tile_cnt;
  logic                     ovf;

  typedef struct packed {
    logic [RW-1:0]       row;
    logic [OUTWIDTH-1:0] data;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;

  col_drain #(.ROWS(ROWS), .OUTWIDTH(OUTWIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_res    (in_res),
    .in_valids (in_valids),
    .out_r     (out_r),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .done      (done),
    .tile_cnt  (tile_cnt),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs change #1 after the edge, strobes are one cycle wide.
  task automatic step();
    @(posedge clk);
    #1;
    in_valids = '0;
  endtask

  task automatic drive_row(input int r, input logic [31:0] v, input bit push);
    beat_t e;
    in_valids[r] = 1'b1;
    in_res[r*OUTWIDTH +: OUTWIDTH] = v;
    if (push) begin
      e.row  = RW'(r);
      e.data = v;
      q.push_back(e);
    end
  endtask

  task automatic drain_tail(input string tag, input logic [15:0] exp_tiles);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_tile_cnt"}, {16'd0, tile_cnt}, {16'd0, exp_tiles});
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    step();
    chk({tag, "_done_clear"}, {31'd0, done}, 32'd0);
    chk({tag, "_q_empty"}, q.size(), 32'd0);
  endtask

  // Handshake monitor: every accepted beat must match the head of the queue.
  always @(negedge clk) begin
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat_row", {30'd0, out_row}, 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("beat_row", {30'd0, out_row}, {30'd0, e.row});
        chk("beat_data", out_r, e.data);
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_r", out_r, 32'd0);
    chk("rst_out_row", {30'd0, out_row}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tile_cnt", {16'd0, tile_cnt}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    out_ready = 1'b1;

    // Tile 1: all rows in one cycle, 1-cycle latency, 4 consecutive beats
    drive_row(0, 32'd10, 1); drive_row(1, 32'd20, 1);
    drive_row(2, 32'd30, 1); drive_row(3, 32'd40, 1);
    step();
    chk("t1_latency", {31'd0, out_valid}, 32'd1);
    repeat (4) step();
    drain_tail("t1", 16'd1);

    // Tile 2: systolic skew, one row per cycle
    drive_row(0, 32'd5, 1); step();
    chk("t2_wait0", {31'd0, out_valid}, 32'd0);
    drive_row(1, 32'd6, 1); step();
    drive_row(2, 32'd7, 1); step();
    chk("t2_wait2", {31'd0, out_valid}, 32'd0);
    drive_row(3, 32'd8, 1); step();
    chk("t2_first_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_first_row", {30'd0, out_row}, 32'd0);
    repeat (4) step();
    drain_tail("t2", 16'd2);

    // Tile 3: backpressure on row 1
    drive_row(0, 32'd10, 1); drive_row(1, 32'd20, 1);
    drive_row(2, 32'd30, 1); drive_row(3, 32'd40, 1);
    step();
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_stall_row", {30'd0, out_row}, 32'd1);
      chk("t3_stall_data", out_r, 32'd20);
      step();
    end
    out_ready = 1'b1;
    chk("t3_release_row", {30'd0, out_row}, 32'd1);
    repeat (3) step();
    drain_tail("t3", 16'd3);

    // Tile 4: next-tile captures during drain, incl. same-cycle handshake
    drive_row(0, 32'd10, 1); drive_row(1, 32'd20, 1);
    drive_row(2, 32'd30, 1); drive_row(3, 32'd40, 1);
    step();
    step();
    drive_row(0, 32'd50, 1); drive_row(1, 32'd60, 1);
    step();
    chk("t4_no_ovf", {31'd0, ovf}, 32'd0);
    step();
    step();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_tile_cnt", {16'd0, tile_cnt}, 32'd4);
    step();
    chk("t4_partial_collect", {31'd0, out_valid}, 32'd0);
    drive_row(2, 32'd70, 1); drive_row(3, 32'd80, 1);
    step();
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_first_data", out_r, 32'd50);
    repeat (4) step();
    drain_tail("t5", 16'd5);
    chk("t5_no_ovf", {31'd0, ovf}, 32'd0);

    // Tile 6: overrun on row 2 drops the second value
    drive_row(0, 32'd10, 1); drive_row(1, 32'd20, 1); drive_row(2, 32'd30, 1);
    step();
    drive_row(2, 32'd99, 0);
    step();
    chk("t6_ovf", {31'd0, ovf}, {31'd0, OVF_EN});
    drive_row(3, 32'd40, 1);
    step();
    chk("t6_valid", {31'd0, out_valid}, 32'd1);
    repeat (4) step();
    drain_tail("t6", 16'd6);
    chk("t6_ovf_sticky", {31'd0, ovf}, {31'd0, OVF_EN});

    // Reset mid-drain after the row 1 beat
    drive_row(0, 32'd11, 1); drive_row(1, 32'd12, 1);
    drive_row(2, 32'd13, 0); drive_row(3, 32'd14, 0);
    step();
    step();
    step();
    rst       = 1'b1;
    out_ready = 1'b0;
    step();
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_r", out_r, 32'd0);
    chk("mr_out_row", {30'd0, out_row}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_tile_cnt", {16'd0, tile_cnt}, 32'd0);
    chk("mr_ovf", {31'd0, ovf}, 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step();
    chk("mr_no_done", {31'd0, done}, 32'd0);
    chk("mr_idle", {31'd0, out_valid}, 32'd0);
    chk("mr_q_empty", q.size(), 32'd0);
    drive_row(0, 32'd1, 1); drive_row(1, 32'd2, 1);
    drive_row(2, 32'd3, 1); drive_row(3, 32'd4, 1);
    step();
    chk("t7_valid", {31'd0, out_valid}, 32'd1);
    repeat (4) step();
    drain_tail("t7", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/col_drain.md
# col_drain

Column result drain for the systolic PE array. It takes the per-row 32-bit results and result-valid strobes of one array column, holds each row's result until the whole tile column is present, then streams the results out row by row over a valid/ready interface to the output buffer. One instance sits below each array column. It is the reader side of the array's result/resvalid outputs.

## Interface
- ROWS, 8: PE rows in the column; must be ≥ 2.
- OUTWIDTH, 32: result width.
- RW, $clog2(ROWS): row-index width (derived localparam).

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_res  in  ROWS*OUTWIDTH  row r result at [r*OUTWIDTH +: OUTWIDTH].
- in_valids  in  ROWS  bit r: one-cycle strobe, in_res row r valid this cycle.
- out_r  out  OUTWIDTH  drained result.
- out_row  out  RW  row index of out_r.
- out_valid  out  1  out_r/out_row valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- done  out  1  one-cycle pulse: tile column fully drained.
- tile_cnt  out  16  completed tiles, wraps at 2^16.
- ovf  out  1  sticky overrun flag; see Configuration.

## Operation
- Per-row state: hold[r] (OUTWIDTH), pend[r] (1 bit). State machine: COLLECT (reset state), DRAIN. Drain pointer ptr (RW bits).
- Capture, either state: if in_valids[r] and !pend[r], then hold[r] <= row r of in_res and pend[r] <= 1.
- Overrun: in_valids[r] while pend[r]=1 and row r is not being released this cycle. The new value is dropped, hold[r] is unchanged, and the ovf condition is raised.
- COLLECT: out_valid=0. When pend is all ones, go to DRAIN with ptr=0.
- DRAIN: out_valid=1, out_r=hold[ptr], out_row=ptr (combinational from registers).
  - On handshake, pend[ptr] <= 0.
  - If ptr<ROWS-1, ptr++.
  - If ptr==ROWS-1, go to COLLECT, reset ptr to 0, pulse done next cycle, and increment tile_cnt.
- Same-cycle handshake on row ptr plus in_valids[ptr]: capture wins. pend[ptr] stays 1, hold[ptr] takes the new value, and there is no overrun. The handshaken beat carries the old value.
- Rows already drained in the current tile may capture next-tile results during DRAIN. These values are retained into the next COLLECT.
- out_row is the row index only and is not reordered.

## Timing
- Reset values: out_valid 0, out_r 0, out_row 0, done 0, tile_cnt 0, ovf 0, all hold 0, pend 0, state COLLECT.
- Capture at edge N is visible in pend at N+1.
- If the last row is captured at edge N, out_valid is high from cycle N+1 (1-cycle latency).
- With out_ready held high, the drain takes exactly ROWS consecutive cycles, one row per cycle.
- Final handshake at cycle M: done=1 and tile_cnt updated in cycle M+1, with state COLLECT. If pend is all ones at M+1, DRAIN starts at M+2, giving a minimum 1-cycle bubble between tiles.
- Backpressure: while out_valid && !out_ready, out_r and out_row are stable and ptr holds.
- rst mid-operation clears all state within one edge. Held data is discarded and no done pulse is issued.

## Configuration
- COL_DRAIN_OVF_EN defined: ovf is set on any overrun and stays 1 until rst.
- COL_DRAIN_OVF_EN undefined: overrun detection logic is omitted and ovf is tied 0. Drop-on-overrun data behaviour is identical in both builds.

## Test plan
- ROWS=4, all in_valids=1 in one cycle with 10,20,30,40, out_ready=1 → out_valid next cycle. Beats are (row0,10), (row1,20), (row2,30), (row3,40) on consecutive cycles. done pulses once, then tile_cnt=1.
- Systolic skew: row r strobe at cycle r (values 5,6,7,8) → out_valid first high at cycle 4, order row0..row3.
- Backpressure: out_ready low for 3 cycles on beat row1 → out_r=20 and out_row=1 stable throughout, then row1 is delivered once on release. Four beats total.
- Overrun: row2 strobed with 30 then 99 before the tile completes → drains 30. ovf=1 with COL_DRAIN_OVF_EN, ovf=0 without.
- Overlap: during drain, row0 strobed with 50 after its handshake, and row1 strobed with 60 in the same cycle as its handshake → both captured, no ovf. The next tile emits 50, 60 once rows 2 and 3 arrive.
- rst asserted mid-drain after beat row1 → all outputs at reset values next cycle, tile_cnt=0. A following tile of 1,2,3,4 drains correctly.
